// File: rtl/alu_seq_pkg.sv
// Shared constants, op encodings and FSM state type for the ALU sequencer.
// Optional readback port is enabled by defining ALU_SEQ_READBACK_EN.
package alu_seq_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NREG   = 4;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned OP_W   = 2;

   localparam logic [OP_W-1:0] OP_ADD = 2'b00;
   localparam logic [OP_W-1:0] OP_SUB = 2'b01;
   localparam logic [OP_W-1:0] OP_INC = 2'b10;
   localparam logic [OP_W-1:0] OP_XOR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command handshake and direct-load bus of the ALU sequencer.
interface alu_sequencer_if;

   logic                              cmd_valid;
   logic                              cmd_ready;
   logic [alu_seq_pkg::OP_W-1:0]      cmd_op;
   logic [alu_seq_pkg::ADDR_W-1:0]    cmd_srca;
   logic [alu_seq_pkg::ADDR_W-1:0]    cmd_srcb;
   logic [alu_seq_pkg::ADDR_W-1:0]    cmd_dst;
   logic                              ld_valid;
   logic [alu_seq_pkg::ADDR_W-1:0]    ld_addr;
   logic [alu_seq_pkg::DATA_W-1:0]    ld_data;

   modport master (
      output cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_dst,
      output ld_valid, ld_addr, ld_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_dst,
      input  ld_valid, ld_addr, ld_data,
      output cmd_ready
   );

endinterface

// File: rtl/alu_seq_regfile.sv
// 4x16 register file: two combinational read ports, load and writeback write ports.
// Writeback beats a load to the same address. ALU_SEQ_READBACK_EN adds a third read port.
module alu_seq_regfile
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data
`ifdef ALU_SEQ_READBACK_EN
   ,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data
`endif
);

   logic [DATA_W-1:0] regs [NREG];

   // Reads see pre-edge contents, so an accept reads before any same-edge write.
   assign rd_data_a = regs[rd_addr_a];
   assign rd_data_b = regs[rd_addr_b];
`ifdef ALU_SEQ_READBACK_EN
   assign rb_data   = regs[rb_addr];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '{default: '0};
      end else begin
         for (int i = 0; i < int'(NREG); i++) begin
            if (wb_en && (wb_addr == ADDR_W'(i))) begin
               regs[i] <= wb_data;
            end else if (ld_en && (ld_addr == ADDR_W'(i))) begin
               regs[i] <= ld_data;
            end
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Three-state sequencer driving an external ALU and writing its result back to the register file.
// Define ALU_SEQ_READBACK_EN to add the rd_addr/rd_data register readback port.
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   alu_sequencer_if.slave    bus,
   output logic [DATA_W-1:0] Data_A,
   output logic [DATA_W-1:0] Data_B,
   output logic [OP_W-1:0]   op_sel,
   input  logic [DATA_W-1:0] ALU_out,
   input  logic              Zero,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              zero_flag
`ifdef ALU_SEQ_READBACK_EN
   ,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
`endif
);

   state_e            state;
   state_e            state_nxt;
   logic              accept_c;
   logic              capture_c;
   logic              wb_c;
   logic [ADDR_W-1:0] dst;
   logic [DATA_W-1:0] rd_a_c;
   logic [DATA_W-1:0] rd_b_c;
`ifdef ALU_SEQ_READBACK_EN
   logic [DATA_W-1:0] rb_data_c;
`endif

   alu_seq_regfile u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (bus.cmd_srca),
      .rd_addr_b (bus.cmd_srcb),
      .rd_data_a (rd_a_c),
      .rd_data_b (rd_b_c),
      .ld_en     (bus.ld_valid),
      .ld_addr   (bus.ld_addr),
      .ld_data   (bus.ld_data),
      .wb_en     (wb_c),
      .wb_addr   (dst),
      .wb_data   (result)
`ifdef ALU_SEQ_READBACK_EN
      ,
      .rb_addr   (rd_addr),
      .rb_data   (rb_data_c)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.cmd_valid) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_WB;
         ST_WB:   state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      accept_c  = 1'b0;
      capture_c = 1'b0;
      wb_c      = 1'b0;
      case (state)
         ST_IDLE: accept_c  = bus.cmd_valid;
         ST_EXEC: capture_c = 1'b1;
         ST_WB:   wb_c      = 1'b1;
         default: ;
      endcase
   end

   // Handshake and completion flags are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.cmd_ready <= 1'b1;
         done          <= 1'b0;
      end else begin
         bus.cmd_ready <= (state_nxt == ST_IDLE);
         done          <= (state_nxt == ST_WB);
      end
   end

   // Operands hold until the next accept; zero_flag only follows SUB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Data_A    <= '0;
         Data_B    <= '0;
         op_sel    <= OP_ADD;
         dst       <= '0;
         result    <= '0;
         zero_flag <= 1'b0;
      end else begin
         if (accept_c) begin
            Data_A <= rd_a_c;
            Data_B <= rd_b_c;
            op_sel <= bus.cmd_op;
            dst    <= bus.cmd_dst;
         end
         if (capture_c) begin
            result <= ALU_out;
            if (op_sel == OP_SUB) zero_flag <= Zero;
         end
      end
   end

`ifdef ALU_SEQ_READBACK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else        rd_data <= rb_data_c;
   end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a transaction-level register/flag model predicts each
// completion; a monitor pops predictions whenever done is seen.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   typedef struct {
      logic [15:0] res;
      logic        z;
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] data_a, data_b, alu_out, result;
   logic [1:0]  op_sel;
   logic        zero, done, zero_flag;
`ifdef ALU_SEQ_READBACK_EN
   logic [1:0]  rd_addr;
   logic [15:0] rd_data;
`endif

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .Data_A    (data_a),
      .Data_B    (data_b),
      .op_sel    (op_sel),
      .ALU_out   (alu_out),
      .Zero      (zero),
      .done      (done),
      .result    (result),
      .zero_flag (zero_flag)
`ifdef ALU_SEQ_READBACK_EN
      ,
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Team ALU responder
   always_comb begin
      case (op_sel)
         OP_ADD:  alu_out = data_a + data_b;
         OP_SUB:  alu_out = data_a - data_b;
         OP_INC:  alu_out = data_a + 16'd1;
         default: alu_out = data_a ^ data_b;
      endcase
      zero = (alu_out == 16'd0);
   end

   logic [15:0] mregs [4];
   logic        mzf;
   int          cyc;
   int          last_acc;
   bit          pend;
   logic [1:0]  wdst;
   logic [15:0] wres;
   exp_t        q[$];
   int          checks;
   int          errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      int unsigned s;
      case (op)
         2'd0:    s = (int'(a) + int'(b)) % 65536;
         2'd1:    s = (int'(a) - int'(b) + 65536) % 65536;
         2'd2:    s = (int'(a) + 1) % 65536;
         default: s = 32'(a ^ b);
      endcase
      return 16'(s);
   endfunction

   // One clock: check ready, drive inputs, advance model by one edge. Called at a negedge.
   task automatic tick(input bit v, input logic [1:0] op, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [1:0] dst, input bit lv,
                       input logic [1:0] la, input logic [15:0] ld);
      exp_t e;
      bit   acc;
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(cyc + 1 - last_acc >= 3));
      bus.cmd_valid = v;
      bus.cmd_op    = op;
      bus.cmd_srca  = sa;
      bus.cmd_srcb  = sb;
      bus.cmd_dst   = dst;
      bus.ld_valid  = lv;
      bus.ld_addr   = la;
      bus.ld_data   = ld;
      @(posedge clk);
      cyc++;
      acc = v && (cyc - last_acc >= 3);
      if (acc) begin
         e.a   = mregs[sa];
         e.b   = mregs[sb];
         e.op  = op;
         e.res = ref_alu(op, e.a, e.b);
         if (op == 2'd1) mzf = (e.res == 16'd0);
         e.z   = mzf;
         e.due = cyc + 1;
         q.push_back(e);
      end
      if (lv) mregs[la] = ld;
      if (pend && cyc == last_acc + 2) begin
         mregs[wdst] = wres;
         pend = 1'b0;
      end
      if (acc) begin
         last_acc = cyc;
         pend     = 1'b1;
         wdst     = dst;
         wres     = e.res;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 16'd0);
   endtask

   task automatic load(input logic [1:0] a, input logic [15:0] d);
      tick(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, a, d);
   endtask

   task automatic cmd(input logic [1:0] op, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [1:0] dst);
      tick(1'b1, op, sa, sb, dst, 1'b0, 2'd0, 16'd0);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_data_a", 32'(data_a), 32'd0);
      chk("rst_data_b", 32'(data_b), 32'd0);
      chk("rst_op_sel", 32'(op_sel), 32'd0);
      chk("rst_zero_flag", 32'(zero_flag), 32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      for (int i = 0; i < 4; i++) mregs[i] = 16'd0;
      mzf      = 1'b0;
      pend     = 1'b0;
      last_acc = -100;
      q.delete();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
               chk("done_unexpected", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.due));
               chk("result", 32'(result), 32'(e.res));
               chk("zero_flag", 32'(zero_flag), 32'(e.z));
               chk("data_a_hold", 32'(data_a), 32'(e.a));
               chk("data_b_hold", 32'(data_b), 32'(e.b));
               chk("op_sel_hold", 32'(op_sel), 32'(e.op));
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst_n  = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_srca  = 2'd0;
      bus.cmd_srcb  = 2'd0;
      bus.cmd_dst   = 2'd0;
      bus.ld_valid  = 1'b0;
      bus.ld_addr   = 2'd0;
      bus.ld_data   = 16'd0;
`ifdef ALU_SEQ_READBACK_EN
      rd_addr = 2'd0;
`endif
      @(negedge clk);
      do_reset();

      // ADD r0+r1 -> r2, then read r2 back through another ADD with r3 = 0
      load(2'd0, 16'h0005);
      load(2'd1, 16'h0003);
      cmd(OP_ADD, 2'd0, 2'd1, 2'd2);
      idle(2);
      cmd(OP_ADD, 2'd2, 2'd3, 2'd3);
      idle(2);

      // SUB equal operands sets zero_flag; XOR keeps it
      load(2'd0, 16'h1234);
      load(2'd1, 16'h1234);
      cmd(OP_SUB, 2'd0, 2'd1, 2'd3);
      idle(2);
      cmd(OP_XOR, 2'd0, 2'd0, 2'd2);
      idle(2);

      // INC wraps; following ADD reads the written-back zero
      load(2'd0, 16'hFFFF);
      cmd(OP_INC, 2'd0, 2'd0, 2'd0);
      idle(2);
      cmd(OP_ADD, 2'd0, 2'd1, 2'd2);
      idle(2);

      // cmd_valid held high: accepts every third edge
      for (int i = 0; i < 9; i++) tick(1'b1, OP_ADD, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 16'd0);
      bus.cmd_valid = 1'b0;
      idle(2);

      // Load collides with writeback to r2; load to r1 during EXEC
      load(2'd0, 16'h0005);
      load(2'd1, 16'h0003);
      cmd(OP_ADD, 2'd0, 2'd1, 2'd2);
      load(2'd1, 16'h5555);
      load(2'd2, 16'hAAAA);
      cmd(OP_ADD, 2'd2, 2'd1, 2'd0);
      idle(2);

      // Reset in EXEC abandons the command
      load(2'd3, 16'h0007);
      cmd(OP_ADD, 2'd3, 2'd3, 2'd1);
      do_reset();
      cmd(OP_ADD, 2'd1, 2'd3, 2'd0);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         tick(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom),
              2'($urandom), 1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom));
      end
      bus.cmd_valid = 1'b0;
      bus.ld_valid  = 1'b0;
      idle(4);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
